// File: rtl/axi4_wdrop_bresp_sender.sv
// Routes or sinks W bursts following the RAB's per-AW forward/drop decisions and
// injects a SLVERR B response for every sunk burst into gaps of the master B stream.
module axi4_wdrop_bresp_sender #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_ORDER_DEPTH    = 4,
  parameter int C_BDROP_DEPTH    = 4
) (
  input  logic                            axi4_aclk,
  input  logic                            axi4_arstn,

  input  logic [C_AXI_ID_WIDTH-1:0]       trans_id,
  input  logic                            trans_accept,
  input  logic                            trans_drop,
  output logic                            trans_ready,

  input  logic [C_AXI_DATA_WIDTH-1:0]     s_axi4_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axi4_wstrb,
  input  logic                            s_axi4_wlast,
  input  logic [C_AXI_USER_WIDTH-1:0]     s_axi4_wuser,
  input  logic                            s_axi4_wvalid,
  output logic                            s_axi4_wready,

  output logic [C_AXI_DATA_WIDTH-1:0]     m_axi4_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi4_wstrb,
  output logic                            m_axi4_wlast,
  output logic [C_AXI_USER_WIDTH-1:0]     m_axi4_wuser,
  output logic                            m_axi4_wvalid,
  input  logic                            m_axi4_wready,

  output logic [C_AXI_ID_WIDTH-1:0]       s_axi4_bid,
  output logic [1:0]                      s_axi4_bresp,
  output logic [C_AXI_USER_WIDTH-1:0]     s_axi4_buser,
  output logic                            s_axi4_bvalid,
  input  logic                            s_axi4_bready,

  input  logic [C_AXI_ID_WIDTH-1:0]       m_axi4_bid,
  input  logic [1:0]                      m_axi4_bresp,
  input  logic [C_AXI_USER_WIDTH-1:0]     m_axi4_buser,
  input  logic                            m_axi4_bvalid,
  output logic                            m_axi4_bready
);

  localparam int OA_W = $clog2(C_ORDER_DEPTH);
  localparam int BA_W = $clog2(C_BDROP_DEPTH);

  typedef enum logic {B_IDLE, B_INJECT} b_state_t;

  // Order FIFO of {drop, id}; pointers carry one extra wrap bit
  logic [C_AXI_ID_WIDTH:0]   ord_mem [C_ORDER_DEPTH];
  logic [OA_W:0]             ord_wr_ptr, ord_rd_ptr;
  logic                      ord_empty, ord_full, ord_push, ord_pop;
  logic [C_AXI_ID_WIDTH:0]   ord_head;
  logic                      head_drop;
  logic [C_AXI_ID_WIDTH-1:0] head_id;

  logic [C_AXI_ID_WIDTH-1:0] bd_mem [C_BDROP_DEPTH];
  logic [BA_W:0]             bd_wr_ptr, bd_rd_ptr;
  logic                      bd_empty, bd_full, bd_push, bd_pop;

  b_state_t                  b_state;
  logic                      injecting;

  assign ord_empty = (ord_wr_ptr == ord_rd_ptr);
  assign ord_full  = (ord_wr_ptr[OA_W] != ord_rd_ptr[OA_W]) &&
                     (ord_wr_ptr[OA_W-1:0] == ord_rd_ptr[OA_W-1:0]);
  assign trans_ready = !ord_full;
  assign ord_push  = (trans_accept | trans_drop) & trans_ready;
  assign ord_head  = ord_mem[ord_rd_ptr[OA_W-1:0]];
  assign head_drop = ord_head[C_AXI_ID_WIDTH];
  assign head_id   = ord_head[C_AXI_ID_WIDTH-1:0];

  assign bd_empty = (bd_wr_ptr == bd_rd_ptr);
  assign bd_full  = (bd_wr_ptr[BA_W] != bd_rd_ptr[BA_W]) &&
                    (bd_wr_ptr[BA_W-1:0] == bd_rd_ptr[BA_W-1:0]);

  // W routing: a burst moves only once its AW decision sits at the FIFO head
  always_comb begin
    m_axi4_wvalid = 1'b0;
    s_axi4_wready = 1'b0;
    if (!ord_empty) begin
      if (head_drop) begin
        s_axi4_wready = s_axi4_wlast ? !bd_full : 1'b1;
      end else begin
        m_axi4_wvalid = s_axi4_wvalid;
        s_axi4_wready = m_axi4_wready;
      end
    end
  end

  assign m_axi4_wdata = s_axi4_wdata;
  assign m_axi4_wstrb = s_axi4_wstrb;
  assign m_axi4_wlast = s_axi4_wlast;
  assign m_axi4_wuser = s_axi4_wuser;

  assign ord_pop = s_axi4_wvalid & s_axi4_wready & s_axi4_wlast;
  assign bd_push = ord_pop & head_drop;
  assign bd_pop  = injecting & s_axi4_bready;

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      ord_wr_ptr <= '0;
      ord_rd_ptr <= '0;
      bd_wr_ptr  <= '0;
      bd_rd_ptr  <= '0;
    end else begin
      if (ord_push) ord_wr_ptr <= ord_wr_ptr + (OA_W+1)'(1);
      if (ord_pop)  ord_rd_ptr <= ord_rd_ptr + (OA_W+1)'(1);
      if (bd_push)  bd_wr_ptr  <= bd_wr_ptr + (BA_W+1)'(1);
      if (bd_pop)   bd_rd_ptr  <= bd_rd_ptr + (BA_W+1)'(1);
    end
  end

  // FIFO storage holds data only; validity comes from the reset pointers
  always_ff @(posedge axi4_aclk) begin
    if (ord_push) ord_mem[ord_wr_ptr[OA_W-1:0]] <= {trans_drop, trans_id};
    if (bd_push)  bd_mem[bd_wr_ptr[BA_W-1:0]]   <= head_id;
  end

  // Injection waits for a cycle with no master response pending
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      b_state <= B_IDLE;
    end else begin
      case (b_state)
        B_IDLE:   if (!bd_empty && !m_axi4_bvalid) b_state <= B_INJECT;
        B_INJECT: if (s_axi4_bready) b_state <= B_IDLE;
        default:  b_state <= B_IDLE;
      endcase
    end
  end

  assign injecting     = (b_state == B_INJECT);
  assign s_axi4_bvalid = injecting ? 1'b1 : m_axi4_bvalid;
  assign s_axi4_bid    = injecting ? bd_mem[bd_rd_ptr[BA_W-1:0]] : m_axi4_bid;
  assign s_axi4_bresp  = injecting ? 2'b10 : m_axi4_bresp;
  assign s_axi4_buser  = injecting ? '0 : m_axi4_buser;
  assign m_axi4_bready = injecting ? 1'b0 : s_axi4_bready;

endmodule

// File: tb/tb_axi4_wdrop_bresp_sender.sv
// Scoreboard bench for axi4_wdrop_bresp_sender: directed decisions and bursts, with
// expected master W beats and slave B responses checked by negedge monitors.
module tb_axi4_wdrop_bresp_sender;

  logic        axi4_aclk;
  logic        axi4_arstn;
  logic [3:0]  trans_id;
  logic        trans_accept, trans_drop, trans_ready;
  logic [31:0] s_axi4_wdata, m_axi4_wdata;
  logic [3:0]  s_axi4_wstrb, m_axi4_wstrb;
  logic        s_axi4_wlast, m_axi4_wlast;
  logic [3:0]  s_axi4_wuser, m_axi4_wuser;
  logic        s_axi4_wvalid, s_axi4_wready, m_axi4_wvalid, m_axi4_wready;
  logic [3:0]  s_axi4_bid, m_axi4_bid;
  logic [1:0]  s_axi4_bresp, m_axi4_bresp;
  logic [3:0]  s_axi4_buser, m_axi4_buser;
  logic        s_axi4_bvalid, s_axi4_bready, m_axi4_bvalid, m_axi4_bready;

  axi4_wdrop_bresp_sender dut (
    .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
    .trans_id(trans_id), .trans_accept(trans_accept), .trans_drop(trans_drop),
    .trans_ready(trans_ready),
    .s_axi4_wdata(s_axi4_wdata), .s_axi4_wstrb(s_axi4_wstrb), .s_axi4_wlast(s_axi4_wlast),
    .s_axi4_wuser(s_axi4_wuser), .s_axi4_wvalid(s_axi4_wvalid), .s_axi4_wready(s_axi4_wready),
    .m_axi4_wdata(m_axi4_wdata), .m_axi4_wstrb(m_axi4_wstrb), .m_axi4_wlast(m_axi4_wlast),
    .m_axi4_wuser(m_axi4_wuser), .m_axi4_wvalid(m_axi4_wvalid), .m_axi4_wready(m_axi4_wready),
    .s_axi4_bid(s_axi4_bid), .s_axi4_bresp(s_axi4_bresp), .s_axi4_buser(s_axi4_buser),
    .s_axi4_bvalid(s_axi4_bvalid), .s_axi4_bready(s_axi4_bready),
    .m_axi4_bid(m_axi4_bid), .m_axi4_bresp(m_axi4_bresp), .m_axi4_buser(m_axi4_buser),
    .m_axi4_bvalid(m_axi4_bvalid), .m_axi4_bready(m_axi4_bready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } wbeat_t;

  wbeat_t     w_exp[$];
  logic [5:0] b_exp[$];
  wbeat_t     w_e;
  logic [5:0] b_e;
  int         tests = 0;
  int         fails = 0;

  initial axi4_aclk = 1'b0;
  always #5 axi4_aclk = ~axi4_aclk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi4_aclk);
    #1;
  endtask

  // Monitors: every master W beat and slave B handshake must match the queue head
  always @(negedge axi4_aclk) begin
    if (axi4_arstn && m_axi4_wvalid && m_axi4_wready) begin
      if (w_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL w_unexpected: got beat %0h, expected no beat", m_axi4_wdata);
      end else begin
        w_e = w_exp.pop_front();
        check("m_w_data", 64'(m_axi4_wdata), 64'(w_e.data));
        check("m_w_last", 64'(m_axi4_wlast), 64'(w_e.last));
        check("m_w_user", 64'(m_axi4_wuser), 64'(w_e.data[3:0]));
      end
    end
    if (axi4_arstn && s_axi4_bvalid && s_axi4_bready) begin
      if (b_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got bid %0h resp %0h, expected no response",
                 s_axi4_bid, s_axi4_bresp);
      end else begin
        b_e = b_exp.pop_front();
        check("s_b_id_resp", 64'({s_axi4_bid, s_axi4_bresp}), 64'(b_e));
        check("s_b_user", 64'(s_axi4_buser), 64'd0);
      end
    end
  end

  task automatic decide(input logic [3:0] id, input logic drop);
    check("decide_ready", 64'(trans_ready), 64'd1);
    trans_id = id;
    trans_accept = !drop;
    trans_drop = drop;
    tick();
    trans_accept = 1'b0;
    trans_drop = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic last, input logic chk_drop);
    int   n = 0;
    logic hs;
    s_axi4_wvalid = 1'b1;
    s_axi4_wdata = d;
    s_axi4_wlast = last;
    s_axi4_wstrb = 4'hF;
    s_axi4_wuser = d[3:0];
    forever begin
      @(negedge axi4_aclk);
      hs = s_axi4_wready;
      if (chk_drop) check("drop_m_wvalid", 64'(m_axi4_wvalid), 64'd0);
      tick();
      if (hs) break;
      if (++n > 200) begin
        tests++; fails++;
        $display("FAIL w_timeout: got no wready, required wready for beat %0h", d);
        break;
      end
    end
    s_axi4_wvalid = 1'b0;
    s_axi4_wlast = 1'b0;
  endtask

  task automatic fwd_burst(input logic [31:0] base, input int beats);
    for (int i = 0; i < beats; i++) w_exp.push_back({base + 32'(i), i == beats - 1});
    for (int i = 0; i < beats; i++) w_beat(base + 32'(i), i == beats - 1, 1'b0);
  endtask

  task automatic drop_burst(input logic [31:0] base, input int beats);
    for (int i = 0; i < beats; i++) w_beat(base + 32'(i), i == beats - 1, 1'b1);
  endtask

  task automatic m_b_send(input logic [3:0] id);
    int   n = 0;
    logic hs;
    b_exp.push_back({id, 2'b00});
    m_axi4_bvalid = 1'b1;
    m_axi4_bid = id;
    m_axi4_bresp = 2'b00;
    forever begin
      @(negedge axi4_aclk);
      hs = m_axi4_bready;
      tick();
      if (hs) break;
      if (++n > 200) begin
        tests++; fails++;
        $display("FAIL mb_timeout: got no bready, required bready for id %0h", id);
        break;
      end
    end
    m_axi4_bvalid = 1'b0;
  endtask

  initial begin
    axi4_arstn = 1'b0;
    trans_id = '0; trans_accept = 1'b0; trans_drop = 1'b0;
    s_axi4_wdata = '0; s_axi4_wstrb = '0; s_axi4_wlast = 1'b0; s_axi4_wuser = '0;
    s_axi4_wvalid = 1'b0; m_axi4_wready = 1'b1;
    s_axi4_bready = 1'b1;
    m_axi4_bid = '0; m_axi4_bresp = '0; m_axi4_buser = '0; m_axi4_bvalid = 1'b0;
    repeat (3) tick();
    axi4_arstn = 1'b1;

    // Reset state
    s_axi4_wvalid = 1'b1;
    #1;
    check("rst_trans_ready", 64'(trans_ready), 64'd1);
    check("rst_s_wready", 64'(s_axi4_wready), 64'd0);
    check("rst_m_wvalid", 64'(m_axi4_wvalid), 64'd0);
    check("rst_m_bready", 64'(m_axi4_bready), 64'd1);
    check("rst_s_bvalid0", 64'(s_axi4_bvalid), 64'd0);
    m_axi4_bvalid = 1'b1;
    #1;
    check("rst_s_bvalid1", 64'(s_axi4_bvalid), 64'd1);
    m_axi4_bvalid = 1'b0;
    s_axi4_wvalid = 1'b0;
    tick();

    // 1: forward id 3
    decide(4'd3, 1'b0);
    fwd_burst(32'h3000_0010, 4);
    check("t1_trans_ready", 64'(trans_ready), 64'd1);
    check("t1_fifo_empty_wready", 64'(s_axi4_wready), 64'd0);

    // 2: drop id 5, injection timing and hold
    s_axi4_bready = 1'b0;
    decide(4'd5, 1'b1);
    drop_burst(32'h5000_0020, 4);
    check("t2_not_early", 64'(s_axi4_bvalid), 64'd0);
    tick();
    check("t2_inj_valid", 64'(s_axi4_bvalid), 64'd1);
    check("t2_inj_id", 64'(s_axi4_bid), 64'd5);
    check("t2_inj_resp", 64'(s_axi4_bresp), 64'd2);
    check("t2_inj_mbready", 64'(m_axi4_bready), 64'd0);
    tick();
    check("t2_inj_hold", 64'(s_axi4_bvalid), 64'd1);
    b_exp.push_back({4'd5, 2'b10});
    s_axi4_bready = 1'b1;
    tick();
    check("t2_inj_done", 64'(s_axi4_bvalid), 64'd0);

    // 3: mixed accept 1, drop 2, accept 4
    decide(4'd1, 1'b0);
    decide(4'd2, 1'b1);
    decide(4'd4, 1'b0);
    fwd_burst(32'h1000_0030, 2);
    m_b_send(4'd1);
    b_exp.push_back({4'd2, 2'b10});
    drop_burst(32'h2000_0040, 2);
    repeat (4) tick();
    fwd_burst(32'h4000_0050, 2);
    m_b_send(4'd4);

    // 4: master B 7 pending blocks injection of dropped id 2
    s_axi4_bready = 1'b0;
    m_axi4_bvalid = 1'b1;
    m_axi4_bid = 4'd7;
    m_axi4_bresp = 2'b00;
    decide(4'd2, 1'b1);
    drop_burst(32'h2000_0060, 2);
    repeat (3) tick();
    check("t4_master_first", 64'({s_axi4_bvalid, s_axi4_bid, s_axi4_bresp}), 64'({1'b1, 4'd7, 2'b00}));
    b_exp.push_back({4'd7, 2'b00});
    s_axi4_bready = 1'b1;
    tick();
    m_axi4_bvalid = 1'b0;
    #1;
    check("t4_gap", 64'(s_axi4_bvalid), 64'd0);
    b_exp.push_back({4'd2, 2'b10});
    tick();
    check("t4_inj", 64'({s_axi4_bvalid, s_axi4_bid}), 64'({1'b1, 4'd2}));
    tick();

    // 5: bdrop FIFO full stalls the next dropped wlast; order FIFO full
    s_axi4_bready = 1'b0;
    for (int i = 8; i < 12; i++) decide(4'(i), 1'b1);
    for (int i = 8; i < 12; i++) drop_burst(32'(i) << 4, 1);
    decide(4'd12, 1'b1);
    decide(4'd13, 1'b0);
    decide(4'd14, 1'b0);
    decide(4'd15, 1'b0);
    check("t5_order_full", 64'(trans_ready), 64'd0);
    s_axi4_wvalid = 1'b1;
    s_axi4_wdata = 32'hC0;
    s_axi4_wlast = 1'b1;
    s_axi4_wuser = 4'h0;
    repeat (3) begin
      @(negedge axi4_aclk);
      check("t5_wlast_stall", 64'(s_axi4_wready), 64'd0);
    end
    tick();
    for (int i = 8; i < 13; i++) b_exp.push_back({4'(i), 2'b10});
    s_axi4_bready = 1'b1;
    w_beat(32'hC0, 1'b1, 1'b1);
    check("t5_order_room", 64'(trans_ready), 64'd1);
    fwd_burst(32'hD0, 1);
    fwd_burst(32'hE0, 1);
    fwd_burst(32'hF0, 1);
    repeat (20) tick();

    // 6: reset while injecting and mid dropped burst
    s_axi4_bready = 1'b0;
    decide(4'd6, 1'b1);
    drop_burst(32'h60, 1);
    repeat (2) tick();
    check("t6_injecting", 64'(s_axi4_bvalid), 64'd1);
    decide(4'd9, 1'b1);
    w_beat(32'h90, 1'b0, 1'b1);
    m_axi4_bvalid = 1'b1;
    m_axi4_bid = 4'd3;
    m_axi4_bresp = 2'b00;
    s_axi4_wvalid = 1'b1;
    s_axi4_wdata = 32'h91;
    s_axi4_wlast = 1'b0;
    axi4_arstn = 1'b0;
    tick();
    axi4_arstn = 1'b1;
    #1;
    check("t6_bvalid_pass", 64'({s_axi4_bvalid, s_axi4_bid}), 64'({1'b1, 4'd3}));
    check("t6_wready", 64'(s_axi4_wready), 64'd0);
    check("t6_trans_ready", 64'(trans_ready), 64'd1);
    m_axi4_bvalid = 1'b0;
    s_axi4_wvalid = 1'b0;
    s_axi4_bready = 1'b1;
    repeat (6) tick();
    check("t6_no_inject", 64'(s_axi4_bvalid), 64'd0);

    repeat (5) tick();
    check("w_queue_drained", 64'(w_exp.size()), 64'd0);
    check("b_queue_drained", 64'(b_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
